// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divider producing a
// one-cycle tick and a toggling square wave, with glitch-free divisor updates, pause and clear.
module tick_gen #(
  parameter int                        CNT_W    = 27,
  parameter int                        NUM_CH   = 3,
  parameter int                        SEL_W    = 2,
  parameter logic [CNT_W*NUM_CH-1:0]   DIV_INIT = {27'd100_000, 27'd50_000_000, 27'd2}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic [NUM_CH-1:0] clear,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] div_pending
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [SEL_W-1:0] CH_ID    = SEL_W'(gi);
    localparam logic [CNT_W-1:0] DIV_RST  = DIV_INIT[gi*CNT_W +: CNT_W];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wr_hit;
    logic             wrap;

    always_comb begin
      wr_hit = div_wr && (div_sel == CH_ID);
      wrap   = (cnt_q == div_q - CNT_W'(1));
    end

    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (clear[gi]) begin
        // Clear wins over everything on this channel; a same-cycle write is dropped.
        cnt_d = '0;
        sq_d  = 1'b0;
        if (pend_q) begin
          div_d  = pdiv_q;
          pend_d = 1'b0;
        end
      end else if (div_q == '0) begin
        cnt_d = '0;
        if (wr_hit) begin
          div_d = div_data;
        end
      end else begin
        if (!pause) begin
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            if (pend_q) begin
              div_d  = pdiv_q;
              pend_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // A write coinciding with a wrap stays pending for the following wrap.
        if (wr_hit) begin
          pdiv_d = div_data;
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        div_q  <= DIV_RST;
        pdiv_q <= '0;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick[gi]        = tick_q;
    assign sq[gi]          = sq_q;
    assign div_pending[gi] = pend_q;
  end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed scenarios plus randomized traffic checked every cycle
// against an elapsed-edge reference model.
module tb_tick_gen;

  localparam int CNT_W  = 27;
  localparam int NUM_CH = 3;
  localparam int SEL_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              pause;
  logic [NUM_CH-1:0] clear;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] div_pending;

  tick_gen #(
    .CNT_W   (CNT_W),
    .NUM_CH  (NUM_CH),
    .SEL_W   (SEL_W),
    .DIV_INIT({27'd7, 27'd10, 27'd2})
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .clear      (clear),
    .div_wr     (div_wr),
    .div_sel    (div_sel),
    .div_data   (div_data),
    .tick       (tick),
    .sq         (sq),
    .div_pending(div_pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int en     = 0;

  int init_d [NUM_CH] = '{2, 10, 7};
  int m_age  [NUM_CH];
  int m_d    [NUM_CH];
  int m_pd   [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_sq   [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, en, got, exp);
    end
  endtask

  // Reference: a channel ticks once D active edges have elapsed since its period began.
  task automatic model_edge(input logic p, input logic [NUM_CH-1:0] clr, input logic wr,
                            input logic [SEL_W-1:0] sel, input int data);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_age[c] = 0; m_tick[c] = 0; m_sq[c] = 0; m_pend[c] = 0; m_d[c] = init_d[c];
      end else if (clr[c]) begin
        m_age[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
        if (m_pend[c]) begin m_d[c] = m_pd[c]; m_pend[c] = 0; end
      end else if (m_d[c] == 0) begin
        m_tick[c] = 0;
        if (wr && int'(sel) == c) m_d[c] = data;
      end else begin
        m_tick[c] = 0;
        if (!p) begin
          m_age[c]++;
          if (m_age[c] == m_d[c]) begin
            m_age[c] = 0; m_tick[c] = 1; m_sq[c] = ~m_sq[c];
            if (m_pend[c]) begin m_d[c] = m_pd[c]; m_pend[c] = 0; end
          end
        end
        if (wr && int'(sel) == c) begin m_pd[c] = data; m_pend[c] = 1; end
      end
    end
  endtask

  task automatic step(input logic p, input logic [NUM_CH-1:0] clr, input logic wr,
                      input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] data);
    pause = p; clear = clr; div_wr = wr; div_sel = sel; div_data = data;
    @(posedge clk);
    model_edge(p, clr, wr, sel, int'(data));
    en = rst ? 0 : en + 1;
    if (wr || clr != '0 || rst)
      $display("[%0t] edge=%0d rst=%0b pause=%0b clear=%b wr=%0b sel=%0d data=%0d",
               $time, en, rst, p, clr, wr, sel, data);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("tick%0d", c), 32'(tick[c]), 32'(m_tick[c]));
      check($sformatf("sq%0d", c), 32'(sq[c]), 32'(m_sq[c]));
      check($sformatf("pend%0d", c), 32'(div_pending[c]), 32'(m_pend[c]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq", 32'(sq), 32'd0);
    check("rst_pend", 32'(div_pending), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; clear = '0; div_wr = 1'b0; div_sel = '0; div_data = '0;

    // Defaults: ch0 every 2 edges, ch1 every 10, sq0 period 4
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      idle(1);
      check("t1_tick0", 32'(tick[0]), 32'(en % 2 == 0));
      check("t1_tick1", 32'(tick[1]), 32'(en % 10 == 0));
      check("t1_sq0", 32'(sq[0]), 32'((en / 2) % 2));
    end

    // Mid-period write on ch0 (2 -> 5) at edge 3
    do_reset();
    idle(2);
    step(1'b0, '0, 1'b1, 2'd0, 27'd5);
    check("t2_pend3", 32'(div_pending[0]), 32'd1);
    idle(1);
    check("t2_tick4", 32'(tick[0]), 32'd1);
    check("t2_pend4", 32'(div_pending[0]), 32'd0);
    for (int e = 5; e <= 14; e++) begin
      idle(1);
      check("t2_tick0", 32'(tick[0]), 32'(en == 9 || en == 14));
    end

    // Write coincident with a wrap (ch0, 2 -> 3 at edge 4)
    do_reset();
    idle(3);
    step(1'b0, '0, 1'b1, 2'd0, 27'd3);
    check("t3_tick4", 32'(tick[0]), 32'd1);
    check("t3_pend4", 32'(div_pending[0]), 32'd1);
    for (int e = 5; e <= 12; e++) begin
      idle(1);
      check("t3_tick0", 32'(tick[0]), 32'(en == 6 || en == 9 || en == 12));
    end

    // Pause of 7 cycles mid ch1 period shifts the next tick from 20 to 27
    do_reset();
    idle(12);
    for (int e = 13; e <= 19; e++) begin
      step(1'b1, '0, 1'b0, '0, '0);
      check("t4_pause_tick", 32'(tick), 32'd0);
    end
    for (int e = 20; e <= 30; e++) begin
      idle(1);
      check("t4_tick1", 32'(tick[1]), 32'(en == 27));
    end

    // Clear with pending value and same-cycle write, then reset mid-count
    do_reset();
    idle(11);
    step(1'b0, '0, 1'b1, 2'd1, 27'd4);
    idle(2);
    step(1'b0, 3'b010, 1'b1, 2'd1, 27'd8);
    check("t5_sq1", 32'(sq[1]), 32'd0);
    check("t5_pend1", 32'(div_pending[1]), 32'd0);
    for (int e = 16; e <= 23; e++) begin
      idle(1);
      check("t5_tick1", 32'(tick[1]), 32'(en == 19 || en == 23));
    end
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      idle(1);
      check("t5_rst_tick1", 32'(tick[1]), 32'(en == 10));
    end

    // Boundary divisors on ch2: D=1, then 0, then an out-of-range select
    do_reset();
    step(1'b0, '0, 1'b1, 2'd2, 27'd1);
    step(1'b0, 3'b100, 1'b0, '0, '0);
    for (int e = 3; e <= 8; e++) begin
      idle(1);
      check("t6_tick2", 32'(tick[2]), 32'd1);
      check("t6_sq2", 32'(sq[2]), 32'(en % 2));
    end
    step(1'b0, '0, 1'b1, 2'd2, 27'd0);
    idle(1);
    check("t6_tick10", 32'(tick[2]), 32'd1);
    for (int e = 11; e <= 14; e++) begin
      idle(1);
      check("t6_off_tick2", 32'(tick[2]), 32'd0);
      check("t6_off_sq2", 32'(sq[2]), 32'd0);
    end
    step(1'b0, '0, 1'b1, 2'd3, 27'd1);
    check("t6_sel3_pend", 32'(div_pending), 32'd0);
    for (int e = 16; e <= 18; e++) begin
      idle(1);
      check("t6_sel3_tick2", 32'(tick[2]), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic              p, w;
      logic [NUM_CH-1:0] cl;
      rst = ($urandom_range(0, 199) == 0);
      p   = ($urandom_range(0, 9) == 0);
      w   = ($urandom_range(0, 11) == 0);
      for (int c = 0; c < NUM_CH; c++) cl[c] = ($urandom_range(0, 49) == 0);
      step(p, cl, w, SEL_W'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 12)));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel clock-enable generator. Each channel divides `clk` by a runtime-programmable divisor. For every channel it produces a one-cycle `tick` enable pulse and a registered 50%-duty square wave `sq`. It provides the design's slow-rate strobes (display scan, 1 Hz, 500 Hz, ...) as enables in the single `clk` domain, so no derived clocks are needed. Per-channel divisor changes are glitch-free, and the block supports pause and per-channel clear.

## Interface
- `CNT_W`, 27: width of each channel counter and divisor.
- `NUM_CH`, 3: number of channels (1..16).
- `SEL_W`, 2: width of `div_sel`. Must be ≥ clog2(NUM_CH), minimum 1.
- `DIV_INIT`, {27'd100_000, 27'd50_000_000, 27'd2}: packed reset divisors.
  - Channel i uses `DIV_INIT[i*CNT_W +: CNT_W]`.
  - Default: ch0 = 2, ch1 = 50_000_000, ch2 = 100_000.

- `clk`  in  1  system clock. The block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `pause`  in  1  freezes all counters while high.
- `clear`  in  NUM_CH  per-channel synchronous restart.
- `div_wr`  in  1  divisor write strobe, single cycle.
- `div_sel`  in  SEL_W  channel targeted by the write.
- `div_data`  in  CNT_W  new divisor value.
- `tick`  out  NUM_CH  one-cycle enable pulse per channel period. Registered.
- `sq`  out  NUM_CH  square wave; toggles on every tick. Registered.
- `div_pending`  out  NUM_CH  a written divisor is waiting to take effect.

## Operation
- Per-channel state:
  - counter `cnt`, CNT_W bits
  - active divisor `div`
  - pending divisor `pdiv` with valid flag `div_pending`
- Reset (`rst` = 1): all `cnt` = 0, `tick` = 0, `sq` = 0, `div_pending` = 0, `div` = DIV_INIT slice. `rst` overrides every other input.
- Channel disabled when `div` = 0:
  - `cnt` held at 0, `tick` = 0, `sq` holds its value.
  - A write to a disabled channel loads `div` directly on the next edge. `div_pending` stays 0.
- Counting, when not paused and `div` ≠ 0:
  - If `cnt` = div−1: `cnt` ← 0, `tick` ← 1, `sq` ← ~`sq`.
  - Otherwise: `cnt` ← cnt+1, `tick` ← 0.
- `div` = 1: `tick` is high every cycle and `sq` toggles every cycle.
- Frequencies: tick rate = f_clk/div; sq frequency = f_clk/(2·div). Example: 100 MHz with div = 50_000_000 gives a 1 Hz `sq`.
- Pause (`pause` = 1): every `cnt` and `sq` holds and `tick` is forced to 0. Counting resumes from the held `cnt`.
- Divisor write (`div_wr` = 1, `div_sel` < NUM_CH, channel enabled):
  - `pdiv` ← `div_data` and `div_pending` ← 1. A newer write overwrites an older pending value.
  - At the next wrap (the cycle `tick` is registered high), `div` ← `pdiv` and `div_pending` ← 0. The new period starts from `cnt` = 0.
- A write with `div_sel` ≥ NUM_CH is ignored.
- A write landing in the same cycle as a wrap:
  - The wrap consumes only the previously pending value.
  - The new write becomes pending and applies at the following wrap.
- Writing 0 disables the channel at its next wrap.
- Clear (`clear[i]` = 1): `cnt` ← 0, `tick` ← 0, `sq` ← 0.
  - A pending divisor is applied immediately and `div_pending` ← 0.
  - `clear` has priority over `pause`, wrap and a same-cycle write to that channel (that write is dropped).
- Channels are fully independent. No arithmetic crosses channels.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Edge 1 is the first rising edge sampling `rst` = 0 (or `clear[i]` = 0 after a clear).
  - First `tick[i]` is high after edge D (D = active divisor) and lasts exactly one cycle.
  - Subsequent ticks follow every D edges.
- `sq[i]` toggles in the same cycle `tick[i]` rises. The first high phase starts after edge D.
- Pause of P cycles delays every later tick by exactly P cycles.
- `div_pending` rises 1 cycle after a `div_wr` edge. It falls in the same cycle as the applying `tick`.
- Reset asserted mid-period aborts it. After reset, no `tick` occurs before edge D.

## Test plan
1. Reset, then run defaults, NUM_CH = 3 with ch1 scaled to D = 10:
   - ch0 ticks after edges 2, 4, 6, ...
   - ch1 ticks after edges 10, 20, ...
   - `sq[0]` period = 4 cycles.
2. Divisor write on ch0 (D = 2 → 5) at edge 3, mid-period:
   - `div_pending[0]` = 1 after edge 3.
   - Tick after edge 4 applies the new divisor; `div_pending[0]` → 0.
   - Next ticks after edges 9, 14.
3. Write coincident with a wrap (ch0, D = 2, write D = 3 at edge 4):
   - Tick after edge 4 keeps period 2.
   - Tick after edge 6 applies D = 3; next tick after edge 9.
4. `pause` high for 7 cycles in the middle of a ch1 period (D = 10): every following ch1 tick shifts by 7 cycles, and `tick` stays 0 throughout the pause.
5. `clear[1]` with a same-cycle write and a pending value; `rst` mid-count:
   - The clear edge resets `cnt`/`sq`, applies the pending divisor, and drops the same-cycle write.
   - `rst` mid-count zeroes all outputs and restores DIV_INIT.
6. Boundary divisors:
   - D = 1 gives `tick` constantly high and `sq` alternating each cycle.
   - Writing 0 stops ticks at the next wrap.
   - `div_sel` = 3 (with NUM_CH = 3) changes nothing.
